// File: rtl/header_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// header_filter: store-and-forward packet filter keyed on a masked header_a match.
// Revision: 1.0
// ----------------------------------------------------------------------------
module header_filter #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_enable,
  input  logic [47:0]      cfg_match_addr,
  input  logic [47:0]      cfg_match_mask,
  input  logic             header_a_valid,
  input  logic [47:0]      header_a,
  input  logic             header_b_valid,
  input  logic [47:0]      header_b,
  input  logic             header_c_valid,
  input  logic [47:0]      header_c,
  input  logic             payload_valid,
  input  logic [63:0]      payload,
  input  logic [7:0]       byte_enable,
  input  logic             sop,
  input  logic             eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_payload,
  output logic [7:0]       out_byte_enable,
  output logic             out_sop,
  output logic             out_eop,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 74;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     commit_q, commit_d;
  logic [PW-1:0]     spec_q, spec_d;
  logic              trunc_q, trunc_d;
  logic              overflow_q, overflow_d;
  logic              hdr_vld_q, hdr_vld_d;
  logic [47:0]       hdr_q, hdr_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [EW-1:0]     mem_q [DEPTH];

  logic              accept;
  logic              abort;
  logic [PW-1:0]     base;
  logic [PW-1:0]     spec_nxt;
  logic              full;
  logic              trunc_now;
  logic              hdr_have;
  logic [47:0]       hdr_eff;
  logic              match;
  logic              keep;
  logic              pass_inc;
  logic [1:0]        drop_inc;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [EW-1:0]     wdata;
  logic [EW-1:0]     rd_entry;

  // The header_b/c strobes are accepted but carry nothing this filter needs.
  logic unused_hdr;
  assign unused_hdr = ^{header_b_valid, header_b, header_c_valid, header_c};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    commit_d   = commit_q;
    spec_d     = spec_q;
    trunc_d    = trunc_q;
    overflow_d = overflow_q;
    hdr_vld_d  = hdr_vld_q;
    hdr_d      = hdr_q;
    pass_inc   = 1'b0;
    drop_inc   = 2'd0;
    we         = 1'b0;
    keep       = 1'b0;
    trunc_now  = trunc_q;

    accept   = payload_valid & (sop | (state_q == ST_COLLECT));
    abort    = payload_valid & sop & (state_q == ST_COLLECT);
    // An aborting sop reuses the space of the packet it discards.
    base     = abort ? commit_q : spec_q;
    full     = (base - rd_q) == FULL_LVL;
    spec_nxt = base;
    waddr    = base[AW-1:0];
    wdata    = {sop, eop, byte_enable, payload};
    hdr_have = header_a_valid | (hdr_vld_q & ~abort);
    hdr_eff  = header_a_valid ? header_a : hdr_q;
    match    = ~cfg_enable |
               (((hdr_eff ^ cfg_match_addr) & cfg_match_mask) == 48'd0);

    if (out_valid && out_ready) begin
      rd_d = rd_q + 1'b1;
    end

    if (header_a_valid) begin
      hdr_vld_d = 1'b1;
      hdr_d     = header_a;
    end

    if (accept) begin
      if (sop) begin
        trunc_now = 1'b0;
      end
      if (abort) begin
        drop_inc = 2'd1;
        if (!header_a_valid) begin
          hdr_vld_d = 1'b0;
        end
      end
      if (full) begin
        trunc_now  = 1'b1;
        overflow_d = 1'b1;
      end else begin
        we       = 1'b1;
        spec_nxt = base + 1'b1;
      end

      if (eop) begin
        keep = hdr_have & match & ~trunc_now;
        if (keep) begin
          commit_d = spec_nxt;
          spec_d   = spec_nxt;
          pass_inc = 1'b1;
        end else begin
          spec_d   = commit_q;
          drop_inc = drop_inc + 2'd1;
        end
        hdr_vld_d = 1'b0;
        trunc_d   = 1'b0;
        state_d   = ST_IDLE;
      end else begin
        spec_d  = spec_nxt;
        trunc_d = trunc_now;
        state_d = ST_COLLECT;
      end
    end

    pass_d = sat_add(pass_q, {1'b0, pass_inc});
    drop_d = sat_add(drop_q, drop_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      commit_q   <= '0;
      spec_q     <= '0;
      trunc_q    <= 1'b0;
      overflow_q <= 1'b0;
      hdr_vld_q  <= 1'b0;
      hdr_q      <= '0;
      pass_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      commit_q   <= commit_d;
      spec_q     <= spec_d;
      trunc_q    <= trunc_d;
      overflow_q <= overflow_d;
      hdr_vld_q  <= hdr_vld_d;
      hdr_q      <= hdr_d;
      pass_q     <= pass_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign out_valid = (rd_q != commit_q);
  assign rd_entry  = mem_q[rd_q[AW-1:0]];
  assign {out_sop, out_eop, out_byte_enable, out_payload} = out_valid ? rd_entry : '0;

  assign pass_count = pass_q;
  assign drop_count = drop_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_header_filter.sv
`default_nettype none
// Testbench for header_filter: directed vector table, hand sequences and a
// randomized run checked against a packet-level reference model.
module tb_header_filter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic        clk;
  logic        rst;
  logic        cfg_enable;
  logic [47:0] cfg_match_addr;
  logic [47:0] cfg_match_mask;
  logic        header_a_valid;
  logic [47:0] header_a;
  logic        header_b_valid;
  logic [47:0] header_b;
  logic        header_c_valid;
  logic [47:0] header_c;
  logic        payload_valid;
  logic [63:0] payload;
  logic [7:0]  byte_enable;
  logic        sop;
  logic        eop;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_payload;
  logic [7:0]  out_byte_enable;
  logic        out_sop;
  logic        out_eop;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] drop_count;
  logic        overflow;

  header_filter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_match_addr(cfg_match_addr), .cfg_match_mask(cfg_match_mask),
    .header_a_valid(header_a_valid), .header_a(header_a),
    .header_b_valid(header_b_valid), .header_b(header_b),
    .header_c_valid(header_c_valid), .header_c(header_c),
    .payload_valid(payload_valid), .payload(payload), .byte_enable(byte_enable),
    .sop(sop), .eop(eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_byte_enable(out_byte_enable), .out_sop(out_sop), .out_eop(out_eop),
    .pass_count(pass_count), .drop_count(drop_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [7:0]  be;
    logic [63:0] d;
  } beat_t;

  // Reference model: committed beats awaiting output, beats of the open packet.
  beat_t       outq[$];
  beat_t       cur[$];
  bit          in_pkt, trunc_m, hv_m, ovf_m;
  logic [47:0] hval_m;
  logic [31:0] m_pass, m_drop;
  logic [63:0] captured[$];

  int tests = 0;
  int fails = 0;

  task automatic model_clear();
    outq.delete(); cur.delete();
    in_pkt = 0; trunc_m = 0; hv_m = 0; ovf_m = 0; hval_m = '0;
    m_pass = '0; m_drop = '0;
  endtask

  task automatic clear_inputs();
    payload_valid = 0; header_a_valid = 0; sop = 0; eop = 0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic cyc();
    beat_t eb, b;
    bit    xfer, keep;
    int    occ;
    @(negedge clk);
    eb = (outq.size() != 0) ? outq[0] : '0;
    tests++;
    if (out_valid !== (outq.size() != 0) ||
        (out_valid && {out_sop, out_eop, out_byte_enable, out_payload} !== eb)) begin
      fails++;
      $display("FAIL out_beat: got v=%0b %h want v=%0b %h", out_valid,
               {out_sop, out_eop, out_byte_enable, out_payload}, outq.size() != 0, eb);
    end
    tests++;
    if (pass_count !== m_pass || drop_count !== m_drop || overflow !== ovf_m) begin
      fails++;
      $display("FAIL counters: got pass=%0d drop=%0d ovf=%0b want pass=%0d drop=%0d ovf=%0b",
               pass_count, drop_count, overflow, m_pass, m_drop, ovf_m);
    end
    if (out_valid && out_ready) captured.push_back(out_payload);

    xfer = (outq.size() != 0) && out_ready;
    occ  = outq.size() + cur.size();
    if (payload_valid && sop && in_pkt) begin
      m_drop = sat_inc(m_drop);
      occ    = outq.size();
      cur.delete();
      hv_m   = 0;
    end
    if (header_a_valid) begin
      hv_m = 1; hval_m = header_a;
    end
    if (payload_valid && (sop || in_pkt)) begin
      if (sop) trunc_m = 0;
      b = '{sop: sop, eop: eop, be: byte_enable, d: payload};
      if (occ == DEPTH) begin
        trunc_m = 1; ovf_m = 1;
      end else begin
        cur.push_back(b);
      end
      if (eop) begin
        keep = hv_m && !trunc_m &&
               (!cfg_enable || ((hval_m ^ cfg_match_addr) & cfg_match_mask) == 48'd0);
        if (keep) begin
          foreach (cur[k]) outq.push_back(cur[k]);
          m_pass = sat_inc(m_pass);
        end else begin
          m_drop = sat_inc(m_drop);
        end
        cur.delete(); hv_m = 0; in_pkt = 0;
      end else begin
        in_pkt = 1;
      end
    end
    if (xfer) void'(outq.pop_front());

    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic set_beat(input int id, input int i, input bit s, input bit e,
                          input logic [7:0] be, input bit strobe, input logic [47:0] hdr);
    payload_valid = 1; sop = s; eop = e; byte_enable = be;
    payload = 64'(id * 256 + i);
    header_a_valid = strobe; header_a = hdr;
  endtask

  task automatic send_pkt(input int id, input int n, input bit strobe,
                          input logic [47:0] hdr, input logic [7:0] last_be);
    for (int i = 0; i < n; i++) begin
      set_beat(id, i, i == 0, i == n - 1, (i == n - 1) ? last_be : 8'hFF, strobe && i == 0, hdr);
      cyc();
    end
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 40 && (outq.size() != 0 || out_valid); i++) cyc();
    tests++;
    if (outq.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_timeout: out_valid=%0b model_left=%0d want 0/0", out_valid, outq.size());
    end
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, out_sop, out_eop, out_byte_enable, out_payload,
         pass_count, drop_count, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b data=%h pass=%0d drop=%0d ovf=%0b want all 0",
               out_valid, out_payload, pass_count, drop_count, overflow);
    end
    rst = 0;
    model_clear();
  endtask

  typedef struct {
    bit          en;
    logic [47:0] addr;
    logic [47:0] mask;
    logic [47:0] hdr;
    bit          strobe;
    int          nbeats;
    logic [7:0]  last_be;
    bit          rdy;
    int          exp_pass;
    int          exp_drop;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    logic [31:0] p0, d0;
    logic [63:0] exp6[$];
    rst = 1; cfg_enable = 0; cfg_match_addr = '0; cfg_match_mask = '0;
    header_a = '0; header_b_valid = 0; header_b = '0; header_c_valid = 0; header_c = '0;
    payload = '0; byte_enable = '0; out_ready = 1;
    clear_inputs();
    model_clear();

    vecs[0] = '{0, 48'h0, 48'h0, 48'h123456789ABC, 1, 3, 8'hFF, 1, 1, 0, 0};
    vecs[1] = '{1, 48'h0A0B0C0D0E0F, 48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E00, 1, 3, 8'hFF, 1, 0, 1, 0};
    vecs[2] = '{1, 48'h0A0B0C0D0E0F, 48'hFFFFFFFFFF00, 48'h0A0B0C0D0E00, 1, 3, 8'h0F, 1, 1, 0, 0};
    vecs[3] = '{0, 48'h0, 48'h0, 48'h0, 0, 2, 8'hFF, 1, 0, 1, 0};
    vecs[4] = '{0, 48'h0, 48'h0, 48'h1, 1, 6, 8'hFF, 0, 0, 1, 1};
    vecs[5] = '{0, 48'h0, 48'h0, 48'h1, 1, 2, 8'h03, 0, 1, 0, 1};

    do_reset();

    for (int v = 0; v < 6; v++) begin
      cfg_enable = vecs[v].en; cfg_match_addr = vecs[v].addr; cfg_match_mask = vecs[v].mask;
      out_ready = vecs[v].rdy;
      p0 = pass_count; d0 = drop_count;
      send_pkt(v + 1, vecs[v].nbeats, vecs[v].strobe, vecs[v].hdr, vecs[v].last_be);
      drain();
      tests++;
      if (pass_count - p0 != 32'(vecs[v].exp_pass) || drop_count - d0 != 32'(vecs[v].exp_drop) ||
          overflow !== vecs[v].exp_ovf) begin
        fails++;
        $display("FAIL vec%0d: got dpass=%0d ddrop=%0d ovf=%0b want dpass=%0d ddrop=%0d ovf=%0b",
                 v, pass_count - p0, drop_count - d0, overflow,
                 vecs[v].exp_pass, vecs[v].exp_drop, vecs[v].exp_ovf);
      end
    end

    // Header strobe ahead of sop belongs to the following packet.
    cfg_enable = 1; cfg_match_addr = 48'hA1B2C3D4E5F6; cfg_match_mask = '1;
    p0 = pass_count;
    header_a_valid = 1; header_a = 48'hA1B2C3D4E5F6;
    cyc();
    send_pkt(8'h20, 2, 0, 48'h0, 8'h01);
    drain();
    tests++;
    if (pass_count - p0 != 32'd1) begin
      fails++;
      $display("FAIL presop_hdr: got dpass=%0d want 1", pass_count - p0);
    end

    // Toggled out_ready, back-to-back packets with an abort in the middle.
    cfg_enable = 0;
    captured.delete();
    p0 = pass_count; d0 = drop_count;
    out_ready = 1; set_beat(8'h10, 0, 1, 0, 8'hFF, 1, 48'h0); cyc();
    out_ready = 0; set_beat(8'h10, 1, 0, 1, 8'h7F, 0, 48'h0); cyc();
    out_ready = 1; set_beat(8'h11, 0, 1, 0, 8'hFF, 1, 48'h0); cyc();
    out_ready = 0; set_beat(8'h12, 0, 1, 0, 8'hFF, 1, 48'h0); cyc();
    out_ready = 1; set_beat(8'h12, 1, 0, 1, 8'h3F, 0, 48'h0); cyc();
    out_ready = 0; set_beat(8'h13, 0, 1, 1, 8'h01, 1, 48'h0); cyc();
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 0);
      cyc();
    end
    drain();
    exp6 = '{64'h1000, 64'h1001, 64'h1200, 64'h1201, 64'h1300};
    tests++;
    if (captured != exp6 || pass_count - p0 != 32'd3 || drop_count - d0 != 32'd1) begin
      fails++;
      $display("FAIL abort_order: got n=%0d first=%h dpass=%0d ddrop=%0d want n=5 first=1000 dpass=3 ddrop=1",
               captured.size(), (captured.size() != 0) ? captured[0] : 64'h0,
               pass_count - p0, drop_count - d0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        cfg_enable     = 1'($urandom_range(0, 1));
        cfg_match_addr = 48'({$urandom(), $urandom()});
        cfg_match_mask = 48'({$urandom(), $urandom()});
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) begin
        payload_valid = 1;
        sop           = ($urandom_range(0, 4) == 0);
        eop           = ($urandom_range(0, 3) == 0);
        byte_enable   = 8'($urandom());
        payload       = {$urandom(), $urandom()};
      end
      if ($urandom_range(0, 5) == 0) begin
        header_a_valid = 1;
        if ($urandom_range(0, 1) == 1)
          header_a = cfg_match_addr ^ (48'({$urandom(), $urandom()}) & ~cfg_match_mask);
        else
          header_a = 48'({$urandom(), $urandom()});
      end
      header_b_valid = 1'($urandom()); header_b = 48'({$urandom(), $urandom()});
      cyc();
    end
    drain();

    // Reset in the middle of a packet discards it; traffic restarts cleanly.
    cfg_enable = 0;
    send_pkt(8'h30, 1, 1, 48'h0, 8'hFF);
    set_beat(8'h31, 0, 1, 0, 8'hFF, 1, 48'h0); cyc();
    set_beat(8'h31, 1, 0, 0, 8'hFF, 0, 48'h0); cyc();
    do_reset();
    send_pkt(8'h32, 2, 1, 48'h0, 8'hFF);
    drain();
    tests++;
    if (pass_count !== 32'd1 || drop_count !== 32'd0) begin
      fails++;
      $display("FAIL post_reset: got pass=%0d drop=%0d want pass=1 drop=0", pass_count, drop_count);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
